// File: rtl/seq_detect_ctrl_pkg.sv
// Shared definitions for the programmable serial sequence detector.
// Holds the controller state encoding, default widths and a length-legality helper.
package seq_detect_ctrl_pkg;

   localparam int unsigned DEF_PAT_W = 4;
   localparam int unsigned DEF_LEN_W = 3;
   localparam int unsigned DEF_CNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // A length is usable only if it selects at least one and at most max_len pattern bits.
   function automatic logic len_ok(input int unsigned len, input int unsigned max_len);
      return (len >= 1) && (len <= max_len);
   endfunction

endpackage

// File: rtl/seq_detect_ctrl_match_core.sv
// History shift register, fill counter and masked pattern compare.
// Ports:
//   clk, rst_n   clock and async active-low reset
//   clr          flush history and fill counter (takes priority over shift_en)
//   shift_en     shift seq into the history this edge
//   seq          serial data bit
//   pattern      programmed pattern, last received bit in bit 0
//   len          active pattern length
//   hit          combinational: the history after this edge's shift matches
module seq_match_core
   import seq_detect_ctrl_pkg::*;
#(
   parameter int unsigned PAT_W = DEF_PAT_W,
   parameter int unsigned LEN_W = DEF_LEN_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             shift_en,
   input  logic             seq,
   input  logic [PAT_W-1:0] pattern,
   input  logic [LEN_W-1:0] len,
   output logic             hit
);

   logic [PAT_W-1:0] hist_q, hist_d;
   logic [LEN_W-1:0] fill_q, fill_d;
   logic [PAT_W-1:0] mask;

   always_comb begin
      hist_d = hist_q;
      fill_d = fill_q;
      if (clr) begin
         hist_d = '0;
         fill_d = '0;
      end else if (shift_en) begin
         hist_d = {hist_q[PAT_W-2:0], seq};
         fill_d = (fill_q >= len) ? len : fill_q + 1'b1;
      end
   end

   // Only the low len bits take part in the compare.
   always_comb begin
      mask = '0;
      for (int i = 0; i < int'(PAT_W); i++) begin
         mask[i] = (i < int'(len));
      end
   end

   // Evaluated on the post-shift history so the controller can register the pulse
   // on the same edge that samples the completing bit.
   assign hit = shift_en && !clr && (fill_d >= len) && (((hist_d ^ pattern) & mask) == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_q <= '0;
         fill_q <= '0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
      end
   end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Controller for the programmable serial sequence detector.
// Latches pattern/length/target while idle, arms on start, counts overlapping matches
// and parks in DONE with a sticky done flag once the target count is reached.
// Ports:
//   clk, rst_n                         clock and async active-low reset
//   cfg_we, cfg_pattern, cfg_len,      configuration write (idle only)
//   cfg_target
//   start, abort                       arm / disarm
//   seq, seq_valid                     serial data and its sample strobe
//   detected                           one-cycle match pulse
//   match_cnt                          matches since the last start
//   busy                               high in RUN
//   done, done_ack                     sticky target-reached flag and its clear
module seq_detect_ctrl
   import seq_detect_ctrl_pkg::*;
#(
   parameter int unsigned PAT_W = DEF_PAT_W,
   parameter int unsigned LEN_W = DEF_LEN_W,
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_we,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic [CNT_W-1:0] cfg_target,
   input  logic             start,
   input  logic             abort,
   input  logic             seq,
   input  logic             seq_valid,
   output logic             detected,
   output logic [CNT_W-1:0] match_cnt,
   output logic             busy,
   output logic             done,
   input  logic             done_ack
);

   state_e           state_q, state_d;
   logic [PAT_W-1:0] pat_q, pat_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [CNT_W-1:0] tgt_q, tgt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             det_q, det_d;

   logic             arm;
   logic             shift_en;
   logic             hit;
   logic [CNT_W-1:0] cnt_inc;

   // cfg_we and abort both veto a start in the same cycle.
   assign arm = (state_q == ST_IDLE) && start && !abort && !cfg_we &&
                len_ok(32'(len_q), PAT_W);

   // abort discards anything sampled on its edge, so nothing is shifted either.
   assign shift_en = (state_q == ST_RUN) && seq_valid && !abort;

   assign cnt_inc = cnt_q + 1'b1;

   seq_match_core #(
      .PAT_W (PAT_W),
      .LEN_W (LEN_W)
   ) u_core (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (arm),
      .shift_en (shift_en),
      .seq      (seq),
      .pattern  (pat_q),
      .len      (len_q),
      .hit      (hit)
   );

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      len_d   = len_q;
      tgt_d   = tgt_q;
      cnt_d   = cnt_q;
      det_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (cfg_we) begin
               pat_d = cfg_pattern;
               len_d = cfg_len;
               tgt_d = cfg_target;
            end else if (arm) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (hit) begin
               det_d = 1'b1;
               if (tgt_q == '0) begin
                  // Unlimited mode: saturate instead of wrapping.
                  if (!(&cnt_q)) begin
                     cnt_d = cnt_inc;
                  end
               end else begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == tgt_q) begin
                     state_d = ST_DONE;
                  end
               end
            end
         end
         ST_DONE: begin
            if (done_ack) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pat_q   <= '0;
         len_q   <= '0;
         tgt_q   <= '0;
         cnt_q   <= '0;
         det_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         tgt_q   <= tgt_d;
         cnt_q   <= cnt_d;
         det_q   <= det_d;
      end
   end

   assign detected  = det_q;
   assign match_cnt = cnt_q;
   assign busy      = (state_q == ST_RUN);
   assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: stimulus pushes the expected match_cnt for every
// bit that should complete a match; a monitor pops one entry per detected pulse.
module tb_seq_detect_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cfg_we;
   logic [3:0] cfg_pattern;
   logic [2:0] cfg_len;
   logic [7:0] cfg_target;
   logic       start;
   logic       abort;
   logic       seq;
   logic       seq_valid;
   logic       detected;
   logic [7:0] match_cnt;
   logic       busy;
   logic       done;
   logic       done_ack;

   int         pass_cnt  = 0;
   int         total_cnt = 0;
   logic [7:0] sb_q[$];

   seq_detect_ctrl #(
      .PAT_W (4),
      .LEN_W (3),
      .CNT_W (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_we      (cfg_we),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_target  (cfg_target),
      .start       (start),
      .abort       (abort),
      .seq         (seq),
      .seq_valid   (seq_valid),
      .detected    (detected),
      .match_cnt   (match_cnt),
      .busy        (busy),
      .done        (done),
      .done_ack    (done_ack)
   );

   always #5 clk = ~clk;

   // Monitor: every detected pulse must correspond to a queued expectation.
   always @(negedge clk) begin
      if (rst_n && detected) begin
         total_cnt++;
         if (sb_q.size() == 0) begin
            $display("FAIL unexpected_detect: got pulse with match_cnt=%0d, required no pulse",
                     match_cnt);
         end else begin
            logic [7:0] exp_cnt;
            exp_cnt = sb_q.pop_front();
            if (match_cnt == exp_cnt) pass_cnt++;
            else $display("FAIL detect_cnt: got match_cnt=%0d, required %0d", match_cnt, exp_cnt);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0d, required %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input logic [3:0] p, input logic [2:0] l, input logic [7:0] t);
      cfg_pattern = p;
      cfg_len     = l;
      cfg_target  = t;
      cfg_we      = 1'b1;
      tick();
      cfg_we      = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_abort();
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic send(input logic b, input logic hit_exp, input logic [7:0] cnt_exp);
      seq       = b;
      seq_valid = 1'b1;
      if (hit_exp) sb_q.push_back(cnt_exp);
      tick();
      seq_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_target = '0;
      start = 1'b0; abort = 1'b0; seq = 1'b0; seq_valid = 1'b0; done_ack = 1'b0;
      #12;
      check("rst_detected", detected, 0);
      check("rst_match_cnt", match_cnt, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Unlimited, overlapping matches
      cfg(4'b1010, 3'd4, 8'd0);
      pulse_start();
      check("t1_busy_after_start", busy, 1);
      check("t1_cnt_after_start", match_cnt, 0);
      send(1, 0, 0); send(0, 0, 0); send(1, 0, 0); send(0, 1, 1);
      send(1, 0, 0); send(0, 1, 2);
      tick();
      check("t1_match_cnt", match_cnt, 2);
      check("t1_done", done, 0);
      check("t1_busy", busy, 1);
      pulse_abort();
      check("t1_abort_idle", busy, 0);
      check("sb_drained_t1", sb_q.size(), 0);

      // Target reached
      cfg(4'b1010, 3'd4, 8'd2);
      pulse_start();
      check("t2_cnt_cleared", match_cnt, 0);
      send(1, 0, 0); send(0, 0, 0); send(1, 0, 0); send(0, 1, 1);
      send(1, 0, 0); send(0, 1, 2);
      check("t2_done_at_edge", done, 1);
      check("t2_busy_drop", busy, 0);
      send(1, 0, 0); send(0, 0, 0);
      tick();
      check("t2_cnt_hold", match_cnt, 2);
      pulse_start();
      check("t2_start_in_done", done, 1);
      pulse_abort();
      check("t2_abort_in_done", done, 1);
      done_ack = 1'b1;
      tick();
      done_ack = 1'b0;
      check("t2_ack_done", done, 0);
      check("t2_ack_busy", busy, 0);
      check("t2_ack_cnt", match_cnt, 2);
      check("sb_drained_t2", sb_q.size(), 0);

      // Gaps and short pattern
      cfg(4'b0011, 3'd2, 8'd0);
      pulse_start();
      send(1, 0, 0);
      tick(); tick(); tick();
      send(1, 1, 1); send(1, 1, 2);
      tick();
      check("t3_match_cnt", match_cnt, 2);
      pulse_abort();
      check("sb_drained_t3", sb_q.size(), 0);

      // Abort on the edge of a would-be match
      cfg(4'b1010, 3'd4, 8'd0);
      pulse_start();
      send(1, 0, 0); send(0, 0, 0); send(1, 0, 0); send(0, 1, 1); send(1, 0, 0);
      seq = 1'b0; seq_valid = 1'b1; abort = 1'b1;
      tick();
      seq_valid = 1'b0; abort = 1'b0;
      check("t4_abort_busy", busy, 0);
      check("t4_abort_cnt", match_cnt, 1);
      check("t4_abort_done", done, 0);
      tick();

      // Illegal lengths and vetoed starts
      cfg(4'b1010, 3'd0, 8'd0);
      pulse_start();
      check("t4_len0_busy", busy, 0);
      cfg(4'b1010, 3'd5, 8'd0);
      pulse_start();
      check("t4_len5_busy", busy, 0);
      cfg(4'b1010, 3'd4, 8'd0);
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      check("t4_start_abort_busy", busy, 0);
      start = 1'b1; cfg_we = 1'b1;
      tick();
      start = 1'b0; cfg_we = 1'b0;
      check("t4_start_cfg_busy", busy, 0);
      check("t4_cnt_untouched", match_cnt, 1);
      check("sb_drained_t4", sb_q.size(), 0);

      // Config lockout in RUN
      pulse_start();
      check("t5_busy", busy, 1);
      cfg(4'b1111, 3'd4, 8'd1);
      send(1, 0, 0); send(0, 0, 0); send(1, 0, 0); send(0, 1, 1);
      send(1, 0, 0); send(1, 0, 0); send(1, 0, 0); send(1, 0, 0);
      tick();
      check("t5_match_cnt", match_cnt, 1);
      check("t5_still_busy", busy, 1);
      check("t5_done", done, 0);
      pulse_abort();
      check("sb_drained_t5", sb_q.size(), 0);

      // Reset mid-run while a detected pulse is high
      pulse_start();
      send(1, 0, 0); send(0, 0, 0); send(1, 0, 0); send(0, 1, 1);
      send(1, 0, 0);
      seq = 1'b0; seq_valid = 1'b1;
      tick();
      seq_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_detected", detected, 0);
      check("t6_rst_cnt", match_cnt, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      pulse_start();
      check("t6_start_len0_busy", busy, 0);
      tick();
      check("sb_drained_final", sb_q.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Controller for the team's serial sequence detector. It holds a programmable pattern and length, and arms and disarms detection on the `seq` stream. It counts overlapping matches and stops after a target count, then raises a sticky `done` that software clears with `done_ack`. It sits between the config/control logic and the raw serial input. It replaces the fixed-pattern detector wherever run-time pattern selection is needed.

Parameters:
- PAT_W, 4, maximum pattern length in bits (must be ≥2).
- LEN_W, 3, width of the length field; must hold the value PAT_W.
- CNT_W, 8, width of the match counter and the target field.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- cfg_we, input, 1, latch cfg_pattern, cfg_len and cfg_target (honoured only in IDLE).
- cfg_pattern, input, PAT_W, pattern; the first bit received maps to bit cfg_len-1, the last bit received maps to bit 0.
- cfg_len, input, LEN_W, active pattern length; valid range 1..PAT_W.
- cfg_target, input, CNT_W, matches before done; 0 means unlimited.
- start, input, 1, arm the detector (single-cycle pulse).
- abort, input, 1, disarm without raising done.
- seq, input, 1, serial data bit.
- seq_valid, input, 1, seq is sampled on this edge.
- detected, output, 1, single-cycle match pulse.
- match_cnt, output, CNT_W, matches counted since the last start.
- busy, output, 1, high while in RUN.
- done, output, 1, sticky: target count reached.
- done_ack, input, 1, clears done.

Behaviour:
- Reset (async, rst_n=0): the following clear immediately.
  - State goes to IDLE.
  - detected, match_cnt, busy and done go to 0.
  - Pattern, length, target, history register and fill counter go to 0.
- States:
  - IDLE→RUN: on start with a latched length in 1..PAT_W and abort=0.
  - RUN→IDLE: on abort.
  - RUN→DONE: on the match that makes match_cnt equal target, when target≠0.
  - DONE→IDLE: on done_ack.
- IDLE:
  - cfg_we latches all three config fields at the edge.
  - start with latched len=0 or len>PAT_W is ignored; the block stays IDLE.
  - start and abort in the same cycle: abort wins, and the block stays IDLE.
  - start and cfg_we in the same cycle: config is latched, start is ignored.
- Entering RUN clears match_cnt, the history register and the fill counter.
- cfg_we outside IDLE is ignored; the latched values are unchanged.
- RUN, on each edge with seq_valid=1:
  - hist <= {hist[PAT_W-2:0], seq}.
  - fill counter increments, saturating at len.
- Match condition, evaluated on the new history at that sampling edge:
  - the new fill count is ≥ len, and
  - the low len bits of hist equal the low len bits of the pattern.
- Match timing and counting:
  - On a match, detected is registered high for exactly the next cycle.
  - match_cnt increments at the same edge and saturates at all-ones when target=0.
- Overlapping matches count: the history is not flushed after a match.
- With seq_valid=0 there is no shift, no fill and no match; gaps of any length are transparent.
- Reaching the target:
  - The final detected pulse and done=1 appear at the same edge; busy drops at that edge.
  - In DONE, seq and seq_valid are ignored and match_cnt holds.
- DONE: start is ignored until done_ack.
  - done_ack returns the block to IDLE with done=0 at the next edge.
  - match_cnt holds until the next start.
- abort in RUN takes effect at that edge.
  - The detector drops to IDLE without done and busy=0.
  - match_cnt holds.
  - A match sampled on the abort edge is discarded.
- abort in DONE has no effect; done_ack is the only exit.
- Reset mid-run: everything returns to reset values asynchronously, including the config registers.

Decomposition:
- Shared package/include:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - default PAT_W, LEN_W and CNT_W constants.
- One natural sub-module, seq_match_core:
  - contains the history shift register, fill counter and masked compare;
  - inputs: clk, rst_n, clr, shift_en, seq, pattern, len;
  - output: a combinational `hit`.
- The controller owns the FSM, counter, target compare and output registers.

Test Plan:
- Unlimited, overlapping: pattern 4'b1010, len 4, target 0, start, then seq 1,0,1,0,1,0 each with seq_valid → detected pulses after the 4th and 6th bits; match_cnt=2; done=0; busy=1.
- Target reached: same pattern, target 2, same stream followed by 1,0 → done=1 at the edge of the 6th bit; no further pulses; match_cnt stays 2. Then done_ack → IDLE, done=0.
- Gaps and short pattern: pattern 2'b11, len 2, target 0, stream 1,(seq_valid=0 for 3 cycles),1,1 → pulses after the 2nd and 3rd valid bits; match_cnt=2.
- Abort and illegal config:
  - abort mid-stream with the 4th matching bit on the same edge → no detected, state IDLE, match_cnt holds.
  - start with len 0 → busy stays 0.
  - start+abort together → IDLE.
- Config lockout: in RUN with pattern 1010, pulse cfg_we with 4'b1111 → the stream 1,0,1,0 still matches, and 1,1,1,1 does not match.
- Reset mid-run: after 3 valid bits of 1010, assert rst_n=0 → all outputs 0 immediately. After release, start without cfg_we is ignored because len=0.
